// File: rtl/frame_buffer_overlap_if.sv
// rtl/frame_buffer_overlap_if.sv - sample stream, frame read and status signals of the overlapping frame buffer
interface frame_buffer_overlap_if #(
    parameter int Q_DATA = 15,
    parameter int DEPTH  = 512
);
    logic                        valid_lowpass;
    logic signed [Q_DATA:0]      data_lowpass;
    logic                        valid_window;
    logic                        paquet_ready;
    logic                        valid_out;
    logic signed [Q_DATA:0]      data_out;
    logic                        frame_last;
    logic [$clog2(DEPTH+1)-1:0]  frames_pending;
    logic                        overflow;

    modport master (
        output valid_lowpass, data_lowpass, valid_window,
        input  paquet_ready, valid_out, data_out, frame_last, frames_pending, overflow
    );

    modport slave (
        input  valid_lowpass, data_lowpass, valid_window,
        output paquet_ready, valid_out, data_out, frame_last, frames_pending, overflow
    );
endinterface

// File: rtl/frame_buffer_overlap.sv
// rtl/frame_buffer_overlap.sv - circular sample buffer serving N-sample frames every HOP samples; FRAMEBUF_DROP_CNT_EN adds drop_count
module frame_buffer_overlap #(
    parameter int Q_DATA = 15,
    parameter int N      = 256,
    parameter int HOP    = 128,
    parameter int DEPTH  = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    frame_buffer_overlap_if.slave bus
`ifdef FRAMEBUF_DROP_CNT_EN
    ,
    output logic [15:0]           drop_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int FW = $clog2(N + 1);

    typedef enum logic {IDLE, READ} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic signed [Q_DATA:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          base_ptr;
    logic [AW-1:0]          rd_addr;
    logic [CW-1:0]          occ;
    logic [CW-1:0]          pending;
    logic [FW-1:0]          fill_cnt;
    logic [RW-1:0]          rd_idx;
    logic                   accept;
    logic                   drop;
    logic                   complete;
    logic                   issue;
    logic                   last_issue;

    // Strobes for this cycle and the read FSM next state
    always_comb begin
        state_nxt  = state;
        accept     = bus.valid_lowpass && (occ != CW'(DEPTH));
        drop       = bus.valid_lowpass && (occ == CW'(DEPTH));
        complete   = accept && (fill_cnt == FW'(1));
        issue      = bus.valid_window && ((state == READ) || (pending != '0));
        last_issue = issue && (rd_idx == RW'(N - 1));
        rd_addr    = base_ptr + AW'(rd_idx);
        case (state)
            IDLE:    if (issue && !last_issue) state_nxt = READ;
            READ:    if (last_issue)           state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Sample storage; left uninitialised across reset
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= bus.data_lowpass;
    end

    // Pointers, occupancy, frame counters; fill_cnt counts down to the next frame completion
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            base_ptr <= '0;
            occ      <= '0;
            pending  <= '0;
            fill_cnt <= FW'(N);
            rd_idx   <= '0;
        end else begin
            if (accept) begin
                wr_ptr   <= wr_ptr + 1'b1;
                fill_cnt <= complete ? FW'(HOP) : fill_cnt - 1'b1;
            end
            occ <= occ + CW'(accept) - (last_issue ? CW'(HOP) : '0);
            if (complete && !last_issue)      pending <= pending + 1'b1;
            else if (!complete && last_issue) pending <= pending - 1'b1;
            if (last_issue) begin
                base_ptr <= base_ptr + AW'(HOP);
                rd_idx   <= '0;
            end else if (issue) begin
                rd_idx   <= rd_idx + 1'b1;
            end
        end
    end

    // Registered outputs; data_out keeps its last value between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.valid_out    <= 1'b0;
            bus.data_out     <= '0;
            bus.frame_last   <= 1'b0;
            bus.paquet_ready <= 1'b0;
            bus.overflow     <= 1'b0;
        end else begin
            bus.valid_out    <= issue;
            bus.frame_last   <= last_issue;
            bus.paquet_ready <= complete;
            if (issue) bus.data_out <= mem[rd_addr];
            if (drop)  bus.overflow <= 1'b1;
        end
    end

    assign bus.frames_pending = pending;

`ifdef FRAMEBUF_DROP_CNT_EN
    // Saturating count of dropped samples
    always_ff @(posedge clk) begin
        if (reset)                             drop_count <= '0;
        else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_frame_buffer_overlap.sv
// tb/tb_frame_buffer_overlap.sv - directed and randomized self-checking bench for frame_buffer_overlap
module tb_frame_buffer_overlap;
    localparam int QD = 15, N = 8, HOP = 4, DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    frame_buffer_overlap_if #(.Q_DATA(QD), .DEPTH(DEPTH)) bus();
`ifdef FRAMEBUF_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    frame_buffer_overlap #(.Q_DATA(QD), .N(N), .HOP(HOP), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef FRAMEBUF_DROP_CNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: absolute sample stream since reset; frame k covers samples k*HOP .. k*HOP+N-1
    logic signed [QD:0] stream[$];
    int  written, completed, frames_read, rd_m, drops;
    bit  in_frame, ovf_m, armed;
    bit  exp_valid, exp_last, exp_ready;
    logic signed [QD:0] exp_data;

    task automatic model_step();
        int occ_m, pend_old;
        bit issue;
        if (reset) begin
            stream.delete();
            written = 0; completed = 0; frames_read = 0; rd_m = 0; drops = 0;
            in_frame = 0; ovf_m = 0; armed = 1;
            exp_valid = 0; exp_last = 0; exp_ready = 0; exp_data = '0;
            return;
        end
        occ_m    = written - HOP * frames_read;
        pend_old = completed - frames_read;
        issue    = bus.valid_window && (in_frame || pend_old > 0);
        exp_valid = issue; exp_last = 0; exp_ready = 0;
        if (issue) begin
            exp_data = stream[frames_read * HOP + rd_m];
            if (rd_m == N - 1) begin
                exp_last = 1; rd_m = 0; in_frame = 0; frames_read++;
            end else begin
                rd_m++; in_frame = 1;
            end
        end
        if (bus.valid_lowpass) begin
            if (occ_m == DEPTH) begin
                ovf_m = 1;
                if (drops < 65535) drops++;
            end else begin
                stream.push_back(bus.data_lowpass);
                written++;
                if (written >= N && (written - N) % HOP == 0) begin
                    completed++; exp_ready = 1;
                end
            end
        end
    endtask

    // Every-cycle comparison of the DUT against the model
    initial begin
        armed = 0;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            if (armed) begin
                chk("m_valid_out", bus.valid_out, exp_valid);
                chk("m_frame_last", bus.frame_last, exp_last);
                chk("m_paquet_ready", bus.paquet_ready, exp_ready);
                chk("m_data_out", $signed(bus.data_out), exp_data);
                chk("m_frames_pending", bus.frames_pending, completed - frames_read);
                chk("m_overflow", bus.overflow, ovf_m);
`ifdef FRAMEBUF_DROP_CNT_EN
                chk("m_drop_count", drop_count, drops);
`endif
            end
        end
    end

    task automatic cyc(input bit vl, input int d, input bit vw);
        @(negedge clk);
        reset = 1'b0;
        bus.valid_lowpass = vl;
        bus.data_lowpass  = 16'(d);
        bus.valid_window  = vw;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.valid_lowpass = 0; bus.data_lowpass = '0; bus.valid_window = 0;
        @(posedge clk);
        #2;
        chk("rst_valid_out", bus.valid_out, 0);
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_frame_last", bus.frame_last, 0);
        chk("rst_paquet_ready", bus.paquet_ready, 0);
        chk("rst_frames_pending", bus.frames_pending, 0);
        chk("rst_overflow", bus.overflow, 0);
`ifdef FRAMEBUF_DROP_CNT_EN
        chk("rst_drop_count", drop_count, 0);
`endif
    endtask

    task automatic write_seq(input int from, input int to);
        for (int i = from; i <= to; i++) cyc(1, i, 0);
    endtask

    task automatic read_frame(input int first);
        for (int k = 0; k < N; k++) begin
            cyc(0, 0, 1);
            chk("frm_valid", bus.valid_out, 1);
            chk("frm_data", $signed(bus.data_out), first + k);
            chk("frm_last", bus.frame_last, (k == N - 1) ? 1 : 0);
        end
    endtask

    initial begin
        bit vw;
        int got, cycles, pw, pr;
        logic [6:0] pat;
        bus.valid_lowpass = 0; bus.data_lowpass = '0; bus.valid_window = 0;

        // First frame forms on the 8th write, then overlap 5..12
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            cyc(1, i, 0);
            chk("s1_no_ready", bus.paquet_ready, 0);
        end
        cyc(1, 8, 0);
        chk("s1_ready", bus.paquet_ready, 1);
        chk("s1_pending", bus.frames_pending, 1);
        cyc(0, 0, 0);
        chk("s1_ready_once", bus.paquet_ready, 0);
        read_frame(1);
        chk("s2_pending0", bus.frames_pending, 0);
        write_seq(9, 12);
        chk("s2_pending1", bus.frames_pending, 1);
        read_frame(5);
        chk("s2_pending_end", bus.frames_pending, 0);

        // Full buffer, drop, recover
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            cyc(1, i, 0);
            if (i >= 8 && i % 4 == 0) chk("s3_pending", bus.frames_pending, (i - 4) / 4);
        end
        cyc(1, 17, 0);
        chk("s3_overflow", bus.overflow, 1);
        chk("s3_pending_hold", bus.frames_pending, 3);
`ifdef FRAMEBUF_DROP_CNT_EN
        chk("s3_drop_count", drop_count, 1);
`endif
        read_frame(1);
        cyc(1, 17, 0);
        chk("s3_overflow_sticky", bus.overflow, 1);
        read_frame(5);

        // Frame-read end coincides with next frame completion
        do_reset();
        write_seq(1, 11);
        for (int k = 0; k < N - 1; k++) cyc(0, 0, 1);
        cyc(1, 12, 1);
        chk("s4_last", bus.frame_last, 1);
        chk("s4_data", $signed(bus.data_out), 8);
        chk("s4_ready", bus.paquet_ready, 1);
        chk("s4_pending", bus.frames_pending, 1);
        cyc(0, 0, 0);
        chk("s4_ready_once", bus.paquet_ready, 0);
        read_frame(5);

        // Reads with nothing pending, then gapped reads
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1);
            chk("s5_no_valid", bus.valid_out, 0);
        end
        write_seq(1, 8);
        pat = 7'b1011001;
        got = 0; cycles = 0;
        while (got < N && cycles < 40) begin
            vw = pat[cycles % 7];
            cyc(0, 0, vw);
            chk("s5_valid", bus.valid_out, vw);
            if (bus.valid_out) begin
                got++;
                chk("s5_data", $signed(bus.data_out), got);
            end
            cycles++;
        end
        chk("s5_count", got, N);
        chk("s5_pending", bus.frames_pending, 0);

        // Reset mid-read abandons the frame
        do_reset();
        write_seq(1, 17);
        chk("s6_overflow", bus.overflow, 1);
        for (int k = 1; k <= 3; k++) begin
            cyc(0, 0, 1);
            chk("s6_data", $signed(bus.data_out), k);
        end
        do_reset();
        write_seq(101, 107);
        chk("s6_no_ready", bus.paquet_ready, 0);
        cyc(1, 108, 0);
        chk("s6_ready", bus.paquet_ready, 1);
        read_frame(101);

        // Randomized traffic against the model
        pw = 50; pr = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                pw = $urandom_range(10, 95);
                pr = $urandom_range(10, 95);
            end
            @(negedge clk);
            reset = ($urandom_range(0, 399) == 0);
            bus.valid_lowpass = ($urandom_range(0, 99) < pw);
            bus.data_lowpass  = 16'($urandom);
            bus.valid_window  = ($urandom_range(0, 99) < pr);
        end
        @(negedge clk);
        reset = 0; bus.valid_lowpass = 0; bus.valid_window = 0;
        repeat (3) @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
